// File: rtl/u3v_leader_trailer_gen.sv
// u3v_leader_trailer_gen: builds U3V leader/trailer packets around each frame and streams them as words.
// Optional build macro TRAILER_TIMESTAMP_EN appends the fall timestamp to the trailer (8 words instead of 6).
module u3v_leader_trailer_gen #(
    parameter int LONG_REG_WD  = 64,
    parameter int SHORT_REG_WD = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_fval,
    input  logic [LONG_REG_WD-1:0]  iv_timestamp,
    input  logic [SHORT_REG_WD-1:0] iv_pixel_format,
    input  logic [SHORT_REG_WD-1:0] iv_size_x,
    input  logic [SHORT_REG_WD-1:0] iv_size_y,
    output logic [SHORT_REG_WD-1:0] ov_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_sop,
    output logic                    o_eop,
    output logic                    o_err
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LEADER  = 2'd1;
    localparam logic [1:0] TRAILER = 2'd2;
`ifdef TRAILER_TIMESTAMP_EN
    localparam int TRL_LEN = 8;
    localparam logic [31:0] TRL_HDR = 32'h0020_0000;
`else
    localparam int TRL_LEN = 6;
    localparam logic [31:0] TRL_HDR = 32'h0018_0000;
`endif

    logic [2:0]              fval_sr;
    logic [1:0]              state;
    logic [3:0]              idx;
    logic [LONG_REG_WD-1:0]  block_id, ts_lead;
`ifdef TRAILER_TIMESTAMP_EN
    logic [LONG_REG_WD-1:0]  ts_trail;
`endif
    logic [SHORT_REG_WD-1:0] pixel_format, size_x, size_y, fval_cnt, fval_len, cnt_next;
    logic lead_pend, trail_pend, frame_open;
    logic rise, fall, rise_ok, fall_ok, accept, lead_last, trail_last;

    assign rise       = fval_sr[2:1] == 2'b01;
    assign fall       = fval_sr[2:1] == 2'b10;
    assign rise_ok    = rise && !lead_pend;
    assign fall_ok    = fall && frame_open;
    assign accept     = o_valid && i_ready;
    assign lead_last  = state == LEADER && idx == 4'd9;
    assign trail_last = state == TRAILER && idx == 4'(TRL_LEN - 1);
    assign cnt_next   = &fval_cnt ? fval_cnt : fval_cnt + 1'b1;

    // Synchronise fval and keep history for edge detection
    always_ff @(posedge clk or posedge reset)
        if (reset) fval_sr <= '0;
        else       fval_sr <= {fval_sr[1:0], i_fval};

    // Capture frame attributes on edges; a rise while the previous leader is still unsent drops the frame
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ts_lead      <= '0;
            pixel_format <= '0;
            size_x       <= '0;
            size_y       <= '0;
            fval_cnt     <= '0;
            fval_len     <= '0;
            frame_open   <= 1'b0;
            o_err        <= 1'b0;
`ifdef TRAILER_TIMESTAMP_EN
            ts_trail     <= '0;
`endif
        end else begin
            o_err    <= rise && lead_pend;
            fval_cnt <= rise ? '0 : cnt_next;
            if (rise_ok) begin
                ts_lead      <= iv_timestamp;
                pixel_format <= iv_pixel_format;
                size_x       <= iv_size_x;
                size_y       <= iv_size_y;
                frame_open   <= 1'b1;
            end else if (fall_ok) begin
                fval_len   <= cnt_next;
                frame_open <= 1'b0;
`ifdef TRAILER_TIMESTAMP_EN
                ts_trail   <= iv_timestamp;
`endif
            end
        end

    // Pending flags: set on capture, cleared when the packet's first word is taken
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            lead_pend  <= 1'b0;
            trail_pend <= 1'b0;
        end else begin
            lead_pend  <= rise_ok || (lead_pend && !(accept && state == LEADER && idx == 4'd0));
            trail_pend <= fall_ok || (trail_pend && !(accept && state == TRAILER && idx == 4'd0));
        end

    // Packet sequencer: word index, state transitions and block ID advance
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            block_id <= '0;
        end else begin
            if (accept && (lead_last || trail_last)) begin
                idx   <= '0;
                state <= lead_last ? (trail_pend ? TRAILER : IDLE) : (lead_pend ? LEADER : IDLE);
            end else if (accept)
                idx <= idx + 4'd1;
            else if (state == IDLE)
                state <= trail_pend ? TRAILER : (lead_pend ? LEADER : IDLE);
            if (accept && trail_last) block_id <= block_id + 1'b1;
        end

    // Word mux: data follows state/index so it holds while stalled
    always_comb begin
        o_valid = state != IDLE;
        o_sop   = o_valid && idx == 4'd0;
        o_eop   = lead_last || trail_last;
        ov_data = '0;
        if (state == LEADER)
            case (idx)
                4'd0:    ov_data = SHORT_REG_WD'(32'h4C56_3355);
                4'd1:    ov_data = SHORT_REG_WD'(32'h0028_0000);
                4'd2:    ov_data = block_id[SHORT_REG_WD-1:0];
                4'd3:    ov_data = block_id[LONG_REG_WD-1 -: SHORT_REG_WD];
                4'd4:    ov_data = SHORT_REG_WD'(32'h0001_0000);
                4'd5:    ov_data = ts_lead[SHORT_REG_WD-1:0];
                4'd6:    ov_data = ts_lead[LONG_REG_WD-1 -: SHORT_REG_WD];
                4'd7:    ov_data = pixel_format;
                4'd8:    ov_data = size_x;
                4'd9:    ov_data = size_y;
                default: ov_data = '0;
            endcase
        else if (state == TRAILER)
            case (idx)
                4'd0:    ov_data = SHORT_REG_WD'(32'h5456_3355);
                4'd1:    ov_data = SHORT_REG_WD'(TRL_HDR);
                4'd2:    ov_data = block_id[SHORT_REG_WD-1:0];
                4'd3:    ov_data = block_id[LONG_REG_WD-1 -: SHORT_REG_WD];
                4'd5:    ov_data = fval_len;
`ifdef TRAILER_TIMESTAMP_EN
                4'd6:    ov_data = ts_trail[SHORT_REG_WD-1:0];
                4'd7:    ov_data = ts_trail[LONG_REG_WD-1 -: SHORT_REG_WD];
`endif
                default: ov_data = '0;
            endcase
    end
endmodule
